// File: rtl/tape_status_writer.sv
// tape_status_writer
// Redraws the cassette overlay whenever the tape moves or a refresh is requested.
// Each sequence writes both gear characters, then every progress-bar segment,
// one character per cycle. A DONE cycle then publishes the filled-segment count.
// Segment fill uses a running threshold (k*max) against pos*SEGS, so no divider is needed.

module tape_status_writer #(
    parameter int          SEGS        = 16,
    parameter int          POS_W       = 25,
    parameter int          ADDR_W      = 12,
    parameter int          BAR_ADDR    = 136,
    parameter int          GEAR_L_ADDR = 331,
    parameter int          GEAR_R_ADDR = 340,
    parameter int          GEAR_PHASES = 2,
    parameter logic [7:0]  CH_GEAR0    = 8'h2A,
    parameter logic [7:0]  CH_GEAR1    = 8'h96,
    parameter logic [7:0]  CH_GEAR2    = 8'h2A,
    parameter logic [7:0]  CH_GEAR3    = 8'h96,
    parameter logic [7:0]  CH_FULL     = 8'h7F,
    parameter logic [7:0]  CH_EMPTY    = 8'hA6
) (
    input  logic              i_clk,
    input  logic              reset,
    input  logic              ena,
    input  logic              refresh,
    input  logic [POS_W-1:0]  pos,
    input  logic [POS_W-1:0]  max,
    output logic              wr_ena,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic [4:0]        filled
);

    localparam int         ACC_W   = POS_W + 5;
    localparam logic [1:0] PH_LAST = 2'(GEAR_PHASES - 1);
    localparam logic [1:0] PH_HALF = 2'(GEAR_PHASES / 2);
    localparam logic [4:0] LAST_K  = 5'(SEGS - 1);

    typedef enum logic [2:0] {
        IDLE,
        GEAR_L,
        GEAR_R,
        BAR,
        DONE
    } state_t;

    state_t state, state_n;

    logic [POS_W-1:0]  pos_r;
    logic              dir;
    logic              gear_step;
    logic              pending;
    logic              change;
    logic              start;

    logic [1:0]        phase, phase_n;
    logic [1:0]        phase_fwd, phase_bwd, opp_sum, phase_opp;
    logic [POS_W-1:0]  pos_s, pos_s_n;
    logic [POS_W-1:0]  max_s, max_s_n;
    logic [ACC_W-1:0]  acc, acc_n;
    logic [4:0]        k, k_n;
    logic [4:0]        cnt, cnt_n;

    logic [ACC_W-1:0]  pos_scaled;
    logic [ACC_W-1:0]  seg_acc;
    logic [4:0]        seg_idx;
    logic              seg_full;

    logic              wr_ena_n;
    logic [ADDR_W-1:0] wr_addr_n;
    logic [7:0]        wr_data_n;
    logic              busy_n;
    logic              done_n;
    logic [4:0]        filled_n;

    function automatic logic [7:0] gear_char(input logic [1:0] p);
        case (p)
            2'd0:    gear_char = CH_GEAR0;
            2'd1:    gear_char = CH_GEAR1;
            2'd2:    gear_char = CH_GEAR2;
            default: gear_char = CH_GEAR3;
        endcase
    endfunction

    assign change = (pos != pos_r);
    assign start  = (state == IDLE) && pending && ena;

    // Track tape movement: remember last position, direction, and whether a redraw is owed.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            pos_r     <= '0;
            dir       <= 1'b0;
            gear_step <= 1'b0;
            pending   <= 1'b0;
        end else begin
            pos_r <= pos;
            if (change) begin
                dir <= (pos < pos_r);
            end
            if (start) begin
                pending   <= 1'b0;
                gear_step <= 1'b0;
            end else begin
                pending   <= pending | change | refresh;
                gear_step <= gear_step | change;
            end
        end
    end

    // Gear phase arithmetic and the per-segment threshold compare used by the FSM.
    always_comb begin
        phase_fwd  = (phase == PH_LAST) ? 2'd0 : phase + 2'd1;
        phase_bwd  = (phase == 2'd0) ? PH_LAST : phase - 2'd1;
        opp_sum    = phase + PH_HALF;
        phase_opp  = (GEAR_PHASES == 4) ? opp_sum : (opp_sum & 2'd1);
        pos_scaled = ACC_W'(pos_s) * ACC_W'(SEGS);
        seg_acc    = (state == BAR) ? acc + ACC_W'(max_s) : acc;
        seg_idx    = (state == BAR) ? k + 5'd1 : k;
        seg_full   = (max_s != '0) && (pos_scaled > seg_acc);
    end

    // Next-state and next-output logic; outputs are registered so they line up with the state.
    always_comb begin
        state_n   = state;
        phase_n   = phase;
        pos_s_n   = pos_s;
        max_s_n   = max_s;
        acc_n     = acc;
        k_n       = k;
        cnt_n     = cnt;
        wr_ena_n  = 1'b0;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        done_n    = 1'b0;
        filled_n  = filled;

        case (state)
            IDLE: begin
                if (start) begin
                    pos_s_n = pos;
                    max_s_n = max;
                    if (gear_step) begin
                        phase_n = dir ? phase_bwd : phase_fwd;
                    end
                    acc_n     = '0;
                    k_n       = '0;
                    cnt_n     = '0;
                    state_n   = GEAR_L;
                    wr_ena_n  = 1'b1;
                    wr_addr_n = ADDR_W'(GEAR_L_ADDR);
                    wr_data_n = gear_char(phase_n);
                end
            end
            GEAR_L: begin
                state_n   = GEAR_R;
                wr_ena_n  = 1'b1;
                wr_addr_n = ADDR_W'(GEAR_R_ADDR);
                wr_data_n = gear_char(phase_opp);
            end
            GEAR_R, BAR: begin
                if (state == BAR && k == LAST_K) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    state_n   = BAR;
                    wr_ena_n  = 1'b1;
                    wr_addr_n = ADDR_W'(BAR_ADDR) + ADDR_W'(seg_idx);
                    wr_data_n = seg_full ? CH_FULL : CH_EMPTY;
                    acc_n     = seg_acc;
                    k_n       = seg_idx;
                    cnt_n     = cnt + {4'b0000, seg_full};
                end
            end
            DONE: begin
                state_n  = IDLE;
                filled_n = cnt;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    // State, snapshot and output registers; reset aborts any sequence at once.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            phase   <= 2'd0;
            pos_s   <= '0;
            max_s   <= '0;
            acc     <= '0;
            k       <= '0;
            cnt     <= '0;
            wr_ena  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            filled  <= '0;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            pos_s   <= pos_s_n;
            max_s   <= max_s_n;
            acc     <= acc_n;
            k       <= k_n;
            cnt     <= cnt_n;
            wr_ena  <= wr_ena_n;
            wr_addr <= wr_addr_n;
            wr_data <= wr_data_n;
            busy    <= busy_n;
            done    <= done_n;
            filled  <= filled_n;
        end
    end

endmodule

// File: tb/tb_tape_status_writer.sv
// Testbench for tape_status_writer: directed scenarios plus randomized pos/max updates,
// each redraw sequence compared against a model built from the fill rule k*max < pos*SEGS.

module tb_tape_status_writer;

    localparam int SEGS     = 16;
    localparam int POS_W    = 25;
    localparam int ADDR_W   = 12;
    localparam int BAR_ADDR = 136;
    localparam int GL_ADDR  = 331;
    localparam int GR_ADDR  = 340;
    localparam int PH       = 4;
    localparam int CH_FULL  = 8'h7F;
    localparam int CH_EMPTY = 8'hA6;

    logic              i_clk = 1'b0;
    logic              reset;
    logic              ena;
    logic              refresh;
    logic [POS_W-1:0]  pos;
    logic [POS_W-1:0]  max;
    logic              wr_ena;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;
    logic              done;
    logic [4:0]        filled;

    tape_status_writer #(
        .SEGS(SEGS), .POS_W(POS_W), .ADDR_W(ADDR_W), .BAR_ADDR(BAR_ADDR),
        .GEAR_L_ADDR(GL_ADDR), .GEAR_R_ADDR(GR_ADDR), .GEAR_PHASES(PH),
        .CH_GEAR0(8'h2A), .CH_GEAR1(8'h96), .CH_GEAR2(8'h3C), .CH_GEAR3(8'h5B),
        .CH_FULL(8'h7F), .CH_EMPTY(8'hA6)
    ) dut (
        .i_clk(i_clk), .reset(reset), .ena(ena), .refresh(refresh),
        .pos(pos), .max(max),
        .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .filled(filled)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int addr;
        int data;
        int cyc;
        int bsy;
    } wr_t;

    wr_t wrQ[$];
    int  cycleNo   = 0;
    int  doneCount = 0;
    int  doneCyc   = 0;
    int  doneBusy  = 0;
    int  doneWr    = 0;
    int  lastFilled = 0;
    bit  doneLast  = 1'b0;

    int  total = 0;
    int  bad   = 0;

    int            phaseM;
    logic [POS_W-1:0] curPos;
    logic [POS_W-1:0] curMax;

    function automatic int gearChar(input int p);
        case (p)
            0:       return 8'h2A;
            1:       return 8'h96;
            2:       return 8'h3C;
            default: return 8'h5B;
        endcase
    endfunction

    // Record every write and each completed sequence, sampled on the falling edge.
    always @(negedge i_clk) begin
        cycleNo++;
        if (reset) begin
            doneLast = 1'b0;
        end else begin
            if (doneLast) begin
                lastFilled = int'(filled);
                doneCount++;
            end
            doneLast = done;
            if (done) begin
                doneCyc  = cycleNo;
                doneBusy = int'(busy);
                doneWr   = int'(wr_ena);
            end
            if (wr_ena) begin
                wrQ.push_back('{int'(wr_addr), int'(wr_data), cycleNo, int'(busy)});
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [POS_W-1:0] p, input logic [POS_W-1:0] m,
                                 input logic r, input logic e);
        @(negedge i_clk);
        pos     = p;
        max     = m;
        refresh = r;
        ena     = e;
        if (r) begin
            @(negedge i_clk);
            refresh = 1'b0;
        end
    endtask

    task automatic expectSequence(input logic [POS_W-1:0] p, input logic [POS_W-1:0] m,
                                  input int ph, input bit gapCheck, input int prevDone);
        int startDone;
        int t;
        int expCnt;
        bit full;
        startDone = doneCount;
        t = 0;
        while (doneCount == startDone && t < 300) begin
            @(posedge i_clk);
            t++;
        end
        checkOutput("seqComplete", 64'(t < 300), 64'd1);
        if (t < 300) begin
            checkOutput("nWrites", 64'(wrQ.size()), 64'(SEGS + 2));
            expCnt = 0;
            for (int k = 0; k < SEGS; k++) begin
                full = (m != 0) && (longint'(p) * SEGS > longint'(k) * longint'(m));
                if (full) expCnt++;
            end
            if (wrQ.size() == SEGS + 2) begin
                checkOutput("gearL_addr", 64'(wrQ[0].addr), 64'(GL_ADDR));
                checkOutput("gearL_data", 64'(wrQ[0].data), 64'(gearChar(ph)));
                checkOutput("gearR_addr", 64'(wrQ[1].addr), 64'(GR_ADDR));
                checkOutput("gearR_data", 64'(wrQ[1].data), 64'(gearChar((ph + PH / 2) % PH)));
                for (int k = 0; k < SEGS; k++) begin
                    full = (m != 0) && (longint'(p) * SEGS > longint'(k) * longint'(m));
                    checkOutput($sformatf("seg%0d_addr", k), 64'(wrQ[k + 2].addr), 64'(BAR_ADDR + k));
                    checkOutput($sformatf("seg%0d_data", k), 64'(wrQ[k + 2].data),
                                64'(full ? CH_FULL : CH_EMPTY));
                end
                for (int i = 0; i < SEGS + 2; i++) begin
                    checkOutput($sformatf("busyWrite%0d", i), 64'(wrQ[i].bsy), 64'd1);
                    if (i > 0) begin
                        checkOutput($sformatf("backToBack%0d", i), 64'(wrQ[i].cyc - wrQ[i - 1].cyc), 64'd1);
                    end
                end
                checkOutput("doneGap", 64'(doneCyc - wrQ[SEGS + 1].cyc), 64'd1);
                if (gapCheck) begin
                    checkOutput("restartGap", 64'(wrQ[0].cyc - prevDone), 64'd2);
                end
            end
            checkOutput("doneBusy", 64'(doneBusy), 64'd1);
            checkOutput("doneNoWrite", 64'(doneWr), 64'd0);
            checkOutput("filled", 64'(lastFilled), 64'(expCnt));
        end
        wrQ.delete();
    endtask

    task automatic stepPos(input logic [POS_W-1:0] p, input logic [POS_W-1:0] m);
        logic r;
        r = (p == curPos);
        if (!r) begin
            phaseM = (p > curPos) ? (phaseM + 1) % PH : (phaseM + PH - 1) % PH;
        end
        applyStimulus(p, m, r, 1'b1);
        curPos = p;
        curMax = m;
        expectSequence(p, m, phaseM, 1'b0, 0);
    endtask

    // Safety net so the run always ends even if some bounded wait is miscounted.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main scenario sequence.
    initial begin
        int t;
        int firstDone;
        int sel;
        logic [POS_W-1:0] np;
        logic [POS_W-1:0] nm;

        reset   = 1'b1;
        ena     = 1'b1;
        refresh = 1'b0;
        pos     = '0;
        max     = 25'd1600;
        repeat (3) @(negedge i_clk);
        checkOutput("rst_wr_ena", 64'(wr_ena), 64'd0);
        checkOutput("rst_wr_addr", 64'(wr_addr), 64'd0);
        checkOutput("rst_wr_data", 64'(wr_data), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_filled", 64'(filled), 64'd0);
        reset = 1'b0;
        repeat (10) @(negedge i_clk);
        checkOutput("idleNoWrites", 64'(wrQ.size()), 64'd0);

        phaseM = 0;
        curPos = '0;
        curMax = 25'd1600;

        $display("[TB] directed fill and gear cases");
        stepPos(25'd1, 25'd1600);
        stepPos(25'd800, 25'd1600);
        stepPos(25'd1600, 25'd1600);
        stepPos(25'd1600, 25'd0);
        stepPos(25'd800, 25'd1600);
        stepPos(25'd799, 25'd1600);
        stepPos(25'd0, 25'd1600);
        stepPos(25'd0, 25'd1600);

        $display("[TB] coalescing changes during a sequence");
        applyStimulus(25'd300, 25'd1600, 1'b0, 1'b1);
        phaseM = (phaseM + 1) % PH;
        t = 0;
        while (!busy && t < 20) begin
            @(negedge i_clk);
            t++;
        end
        checkOutput("coalBusy", 64'(busy), 64'd1);
        applyStimulus(25'd400, 25'd1600, 1'b0, 1'b1);
        applyStimulus(25'd500, 25'd1600, 1'b0, 1'b1);
        applyStimulus(25'd900, 25'd1600, 1'b0, 1'b1);
        expectSequence(25'd300, 25'd1600, phaseM, 1'b0, 0);
        firstDone = doneCyc;
        phaseM = (phaseM + 1) % PH;
        curPos = 25'd900;
        expectSequence(25'd900, 25'd1600, phaseM, 1'b1, firstDone);
        repeat (40) @(negedge i_clk);
        checkOutput("coalNoThird", 64'(wrQ.size()), 64'd0);

        $display("[TB] overlay disabled while tape moves");
        applyStimulus(25'd50, 25'd1600, 1'b0, 1'b0);
        applyStimulus(25'd20, 25'd1600, 1'b0, 1'b0);
        repeat (30) @(negedge i_clk);
        checkOutput("ena0NoWrites", 64'(wrQ.size()), 64'd0);
        checkOutput("ena0Busy", 64'(busy), 64'd0);
        phaseM = (phaseM + PH - 1) % PH;
        curPos = 25'd20;
        applyStimulus(25'd20, 25'd1600, 1'b0, 1'b1);
        expectSequence(25'd20, 25'd1600, phaseM, 1'b0, 0);
        repeat (30) @(negedge i_clk);
        checkOutput("ena1Single", 64'(wrQ.size()), 64'd0);

        $display("[TB] reset in the middle of the bar");
        applyStimulus(25'd1000, 25'd1600, 1'b0, 1'b1);
        t = 0;
        while (!(wr_ena && int'(wr_addr) == BAR_ADDR + 5) && t < 60) begin
            @(negedge i_clk);
            t++;
        end
        checkOutput("rstMidReach", 64'(t < 60), 64'd1);
        #1;
        reset = 1'b1;
        pos   = '0;
        #1;
        checkOutput("rstMid_wr_ena", 64'(wr_ena), 64'd0);
        checkOutput("rstMid_wr_addr", 64'(wr_addr), 64'd0);
        checkOutput("rstMid_wr_data", 64'(wr_data), 64'd0);
        checkOutput("rstMid_busy", 64'(busy), 64'd0);
        checkOutput("rstMid_filled", 64'(filled), 64'd0);
        repeat (3) @(negedge i_clk);
        wrQ.delete();
        reset  = 1'b0;
        phaseM = 0;
        curPos = '0;
        repeat (30) @(negedge i_clk);
        checkOutput("postRstNoWrites", 64'(wrQ.size()), 64'd0);
        stepPos(25'd5, 25'd1600);

        $display("[TB] randomized updates");
        for (int i = 0; i < 24; i++) begin
            sel = int'($urandom_range(0, 7));
            if (sel == 0) begin
                nm = '0;
            end else if (sel < 4) begin
                nm = 25'($urandom_range(1, 5000));
            end else begin
                nm = 25'($urandom);
            end
            sel = int'($urandom_range(0, 4));
            case (sel)
                0:       np = '0;
                1:       np = nm;
                2:       np = nm + 25'($urandom_range(0, 100));
                3:       np = curPos;
                default: np = (nm == '0) ? 25'($urandom) : 25'($urandom % 32'(nm));
            endcase
            stepPos(np, nm);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
